// File: rtl/lcv_limb_pkg.sv
// Shared types and helpers for the limb-serial add/subtract sequencer.
package lcv_limb_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // Limb index width; the limb count is always at least two, so this is never zero.
   function automatic int idx_width(input int num_limbs);
      return $clog2(num_limbs);
   endfunction

   // Two's-complement overflow of a + b': operands agree in sign, result does not.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/LcvAdcDel1.sv
// One-limb adder with carry in and a registered {carry, sum} output (one cycle of latency).
module LcvAdcDel1 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH:0]   res
);

   logic [WIDTH:0] res_d;
   logic [WIDTH:0] res_q;

   always_comb begin
      res_d = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   end

   // NOTE: pure datapath register with no reset; the sequencer never reads it before writing it.
   always_ff @(posedge clk) begin
      res_q <= res_d;
   end

   assign res = res_q;

endmodule

// File: rtl/lcv_limb_adc_seq.sv
// Wide add/subtract performed one limb per cycle through a single registered limb adder,
// chaining the carry from each limb result into the next limb issue.
module lcv_limb_adc_seq
   import lcv_limb_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_LIMBS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       inp_valid,
   output logic                       inp_ready,
   input  logic [NUM_LIMBS*WIDTH-1:0] inp_a,
   input  logic [NUM_LIMBS*WIDTH-1:0] inp_b,
   input  logic                       inp_sub,
   input  logic                       inp_carry,
   output logic                       outp_valid,
   input  logic                       outp_ready,
   output logic [NUM_LIMBS*WIDTH-1:0] outp_sum,
   output logic                       outp_carry,
   output logic                       outp_ovf
);

   localparam int BW    = NUM_LIMBS * WIDTH;
   localparam int IDX_W = idx_width(NUM_LIMBS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] idx_prev;
   logic [BW-1:0]    a_q, a_d;
   logic [BW-1:0]    b_q, b_d;
   logic             cin_q, cin_d;
   logic [BW-1:0]    sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] adder_a;
   logic [WIDTH-1:0] adder_b;
   logic             adder_cin;
   logic [WIDTH:0]   adder_res;

   assign idx_prev  = idx_q - 1'b1;
   assign adder_a   = a_q[idx_q*WIDTH +: WIDTH];
   assign adder_b   = b_q[idx_q*WIDTH +: WIDTH];
   // Limb 0 takes the caller's carry, so stale adder contents never leak into a new request.
   assign adder_cin = (idx_q == '0) ? cin_q : adder_res[WIDTH];

   LcvAdcDel1 #(.WIDTH(WIDTH)) u_adc (
      .clk (clk),
      .a   (adder_a),
      .b   (adder_b),
      .cin (adder_cin),
      .res (adder_res)
   );

   // NOTE: every _d gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (inp_valid) begin
               a_d     = inp_a;
               b_d     = inp_sub ? ~inp_b : inp_b;
               cin_d   = inp_carry;
               sum_d   = '0;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (idx_q != '0) sum_d[idx_prev*WIDTH +: WIDTH] = adder_res[WIDTH-1:0];
            if (idx_q == LAST_IDX) state_d = DRAIN;
            else                   idx_d   = idx_q + 1'b1;
         end
         DRAIN: begin
            sum_d[LAST_IDX*WIDTH +: WIDTH] = adder_res[WIDTH-1:0];
            carry_d = adder_res[WIDTH];
            ovf_d   = signed_ovf(a_q[BW-1], b_q[BW-1], adder_res[WIDTH-1]);
            state_d = DONE;
         end
         DONE: begin
            if (outp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update off the same edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   // Operand latches are always written at accept before use, so they carry no reset.
   always_ff @(posedge clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
   end

   assign inp_ready  = (state_q == IDLE) && !rst;
   assign outp_valid = (state_q == DONE);
   assign outp_sum   = sum_q;
   assign outp_carry = carry_q;
   assign outp_ovf   = ovf_q;

endmodule

// File: tb/tb_lcv_limb_adc_seq.sv
// Randomized and directed bench for lcv_limb_adc_seq against a full-width arithmetic model.
module tb_lcv_limb_adc_seq;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int BW = N * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          inp_valid;
   logic          inp_ready;
   logic [BW-1:0] inp_a;
   logic [BW-1:0] inp_b;
   logic          inp_sub;
   logic          inp_carry;
   logic          outp_valid;
   logic          outp_ready;
   logic [BW-1:0] outp_sum;
   logic          outp_carry;
   logic          outp_ovf;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   lcv_limb_adc_seq #(.WIDTH(W), .NUM_LIMBS(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .inp_valid  (inp_valid),
      .inp_ready  (inp_ready),
      .inp_a      (inp_a),
      .inp_b      (inp_b),
      .inp_sub    (inp_sub),
      .inp_carry  (inp_carry),
      .outp_valid (outp_valid),
      .outp_ready (outp_ready),
      .outp_sum   (outp_sum),
      .outp_carry (outp_carry),
      .outp_ovf   (outp_ovf)
   );

   task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Full-width reference: A + (sub ? ~B : B) + cin, signed overflow from operand/result signs.
   task automatic model(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sub,
                        input logic cin, output logic [BW-1:0] sum, output logic carry,
                        output logic ovf);
      logic [BW:0]   full;
      logic [BW-1:0] bb;
      bb    = sub ? ~b : b;
      full  = {1'b0, a} + {1'b0, bb} + (BW+1)'(cin);
      sum   = full[BW-1:0];
      carry = full[BW];
      ovf   = (a[BW-1] == bb[BW-1]) && (sum[BW-1] != a[BW-1]);
   endtask

   function automatic logic [BW-1:0] rand_wide();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [BW-1:0] rand_operand();
      logic [BW-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b0, {(BW-1){1'b1}}};
         3:       v = {1'b1, {(BW-1){1'b0}}};
         default: v = rand_wide();
      endcase
      return v;
   endfunction

   task automatic issue(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sub,
                        input logic cin);
      @(negedge clk);
      check("idle_ready", {{(BW-1){1'b0}}, inp_ready}, 1);
      inp_a     = a;
      inp_b     = b;
      inp_sub   = sub;
      inp_carry = cin;
      inp_valid = 1'b1;
      @(posedge clk);
      #1;
      inp_valid = 1'b0;
      inp_a     = rand_wide();
      inp_b     = rand_wide();
      inp_sub   = 1'($urandom());
      inp_carry = 1'($urandom());
   endtask

   task automatic run_op(input string tag, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic sub, input logic cin, input int hold);
      logic [BW-1:0] es;
      logic          ec, eo;
      int            edges;
      model(a, b, sub, cin, es, ec, eo);
      issue(a, b, sub, cin);
      edges = 0;
      while (edges < 50) begin
         @(posedge clk);
         #1;
         edges++;
         if (outp_valid) break;
      end
      check({tag, "_latency"}, BW'(edges), BW'(N + 1));
      check({tag, "_sum"}, outp_sum, es);
      check({tag, "_carry"}, {{(BW-1){1'b0}}, outp_carry}, {{(BW-1){1'b0}}, ec});
      check({tag, "_ovf"}, {{(BW-1){1'b0}}, outp_ovf}, {{(BW-1){1'b0}}, eo});
      check({tag, "_busy"}, {{(BW-1){1'b0}}, inp_ready}, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, {{(BW-1){1'b0}}, outp_valid}, 1);
         check({tag, "_hold_ready"}, {{(BW-1){1'b0}}, inp_ready}, 0);
         check({tag, "_hold_sum"}, outp_sum, es);
         check({tag, "_hold_flags"}, {{(BW-2){1'b0}}, outp_carry, outp_ovf},
               {{(BW-2){1'b0}}, ec, eo});
      end
      outp_ready = 1'b1;
      @(posedge clk);
      #1;
      outp_ready = 1'b0;
      check({tag, "_released"}, {{(BW-2){1'b0}}, outp_valid, inp_ready}, 1);
   endtask

   initial begin
      rst        = 1'b1;
      inp_valid  = 1'b0;
      inp_a      = '0;
      inp_b      = '0;
      inp_sub    = 1'b0;
      inp_carry  = 1'b0;
      outp_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {{(BW-1){1'b0}}, inp_ready}, 0);
      check("rst_valid", {{(BW-1){1'b0}}, outp_valid}, 0);
      check("rst_sum", outp_sum, '0);
      check("rst_flags", {{(BW-2){1'b0}}, outp_carry, outp_ovf}, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", {{(BW-1){1'b0}}, inp_ready}, 1);

      run_op("carry_chain", {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, BW'(1),
             1'b0, 1'b0, 0);
      run_op("sub", BW'(5), BW'(7), 1'b1, 1'b1, 0);
      run_op("sovf", {1'b0, {(BW-1){1'b1}}}, BW'(1), 1'b0, 1'b0, 0);
      run_op("cout", '1, '1, 1'b0, 1'b1, 0);
      run_op("backpressure", rand_wide(), rand_wide(), 1'b0, 1'b0, 10);
      run_op("after_bp", rand_wide(), rand_wide(), 1'b1, 1'b1, 0);

      // Reset while limb 2 is being issued; the next request must ignore leftover adder state.
      issue('1, '1, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_valid", {{(BW-1){1'b0}}, outp_valid}, 0);
      check("midrst_sum", outp_sum, '0);
      check("midrst_flags", {{(BW-2){1'b0}}, outp_carry, outp_ovf}, 0);
      rst = 1'b0;
      #1;
      check("midrst_idle", {{(BW-1){1'b0}}, inp_ready}, 1);
      run_op("one_plus_one", BW'(1), BW'(1), 1'b0, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         run_op("rand", rand_operand(), rand_operand(), 1'($urandom()), 1'($urandom()),
                int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
